// File: rtl/mat_loader_pkg.sv
// Shared definitions for the matrix loader: FSM state encoding, the
// ceiling-log2 helper macro and the constants derived from the default
// matrix geometry (8 x 10 elements over GF(3), two elements per word).

`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

package mat_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_RUN,
      ST_UNLOAD
   } state_t;

   localparam int L_DEF = 8;
   localparam int K_DEF = 10;
   localparam int N_DEF = 2;
   localparam int Q_DEF = 3;

   localparam int EW    = `CLOG2(Q_DEF);
   localparam int WW    = N_DEF * EW;
   localparam int DEPTH = L_DEF * K_DEF / N_DEF;
   localparam int AW    = `CLOG2(DEPTH);

endpackage

// File: rtl/mat_loader_if.sv
// Bundle of the host load/unload streams, the systemizer control/status and
// memory port, and the job status flags. The loader is the slave side; the
// host and systemizer together form the master side.

interface mat_loader_if #(
   parameter int WORD_W = mat_loader_pkg::WW,
   parameter int ADDR_W = mat_loader_pkg::AW
);
   logic              cmd_load;
   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [WORD_W-1:0] out_data;
   logic              out_ready;
   logic              sys_start;
   logic              sys_done;
   logic              sys_fail;
   logic              sys_success;
   logic              sys_rd_en;
   logic [ADDR_W-1:0] sys_rd_addr;
   logic [WORD_W-1:0] sys_rd_data;
   logic              sys_wr_en;
   logic [ADDR_W-1:0] sys_wr_addr;
   logic [WORD_W-1:0] sys_wr_data;
   logic              busy;
   logic              res_ok;
   logic              res_fail;
   logic              err_elem;

   modport slave (
      input  cmd_load, in_valid, in_data, out_ready,
             sys_done, sys_fail, sys_success,
             sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data,
      output in_ready, out_valid, out_data, sys_start, sys_rd_data,
             busy, res_ok, res_fail, err_elem
   );

   modport master (
      output cmd_load, in_valid, in_data, out_ready,
             sys_done, sys_fail, sys_success,
             sys_rd_en, sys_rd_addr, sys_wr_en, sys_wr_addr, sys_wr_data,
      input  in_ready, out_valid, out_data, sys_start, sys_rd_data,
             busy, res_ok, res_fail, err_elem
   );
endinterface

// File: rtl/mat_ram.sv
// Matrix storage: one synchronous read port with a registered output that
// holds when no read is issued, and one synchronous write port. A read and a
// write to the same address in one cycle returns the previous contents.

module mat_ram
   import mat_loader_pkg::*;
#(
   parameter int WORD_W    = WW,
   parameter int MEM_DEPTH = DEPTH,
   parameter int ADDR_W    = AW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data
);

   logic [WORD_W-1:0] mem [MEM_DEPTH];

   // Write port.
   // NOTE: the array has no reset so it maps onto RAM macros; contents are undefined until loaded.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read port: registered data, held between reads.
   // NOTE: non-blocking assignment here is what makes a same-address read return the old word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mat_loader.sv
// Job sequencer around the matrix RAM: loads the host stream (scrubbing
// out-of-field elements), starts the systemizer and lends it the RAM, then
// streams the result back through a one-entry prefetch buffer.

module mat_loader
   import mat_loader_pkg::*;
#(
   parameter int L = 8,
   parameter int K = 10,
   parameter int N = 2,
   parameter int Q = 3
) (
   input logic         clk,
   input logic         rst_n,
   mat_loader_if.slave bus
);

   localparam int ELEM_W    = `CLOG2(Q);
   localparam int WORD_W    = N * ELEM_W;
   localparam int MEM_DEPTH = L * K / N;
   localparam int ADDR_W    = `CLOG2(MEM_DEPTH);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ok_q, ok_d, fail_q, fail_d, err_q, err_d;
   logic              pf_valid_q, pf_valid_d;   // prefetch buffer holds an unsent word
   logic              rd_done_q, rd_done_d;     // last unload address has been read
   logic              sys_pend_q;               // systemizer read data is on the RAM output
   logic [WORD_W-1:0] sys_hold_q;               // last systemizer read result

   logic              ram_rd_en, ram_wr_en;
   logic [ADDR_W-1:0] ram_rd_addr, ram_wr_addr;
   logic [WORD_W-1:0] ram_rd_data, ram_wr_data;
   logic [WORD_W-1:0] clean_data;
   logic              bad_elem;
   logic              issue;

   mat_ram #(.WORD_W(WORD_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (ram_rd_en),
      .rd_addr (ram_rd_addr),
      .rd_data (ram_rd_data),
      .wr_en   (ram_wr_en),
      .wr_addr (ram_wr_addr),
      .wr_data (ram_wr_data)
   );

   // Replace any element outside the field with zero and flag it.
   always_comb begin
      clean_data = bus.in_data;
      bad_elem   = 1'b0;
      for (int e = 0; e < N; e++) begin
         if (int'(bus.in_data[e*ELEM_W +: ELEM_W]) >= Q) begin
            clean_data[e*ELEM_W +: ELEM_W] = '0;
            bad_elem = 1'b1;
         end
      end
   end

   // Next-state logic, RAM port muxing and unload prefetch control.
   // NOTE: every signal gets a default first so no path through the case leaves a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ok_d        = ok_q;
      fail_d      = fail_q;
      err_d       = err_q;
      pf_valid_d  = pf_valid_q;
      rd_done_d   = rd_done_q;
      ram_wr_en   = 1'b0;
      ram_wr_addr = cnt_q;
      ram_wr_data = clean_data;
      ram_rd_en   = 1'b0;
      ram_rd_addr = cnt_q;
      issue       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.cmd_load) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               ok_d    = 1'b0;
               fail_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (bus.in_valid) begin
               ram_wr_en = 1'b1;
               if (bad_elem) err_d = 1'b1;
               if (cnt_q == LAST) state_d = ST_START;
               else               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_START: state_d = ST_RUN;
         ST_RUN: begin
            ram_wr_en   = bus.sys_wr_en;
            ram_wr_addr = bus.sys_wr_addr;
            ram_wr_data = bus.sys_wr_data;
            ram_rd_en   = bus.sys_rd_en;
            ram_rd_addr = bus.sys_rd_addr;
            if (bus.sys_done) begin
               state_d   = ST_UNLOAD;
               ok_d      = bus.sys_success;
               fail_d    = bus.sys_fail;
               cnt_d     = '0;
               rd_done_d = 1'b0;
            end
         end
         ST_UNLOAD: begin
            // Refill the buffer whenever it is empty or being drained this cycle.
            issue     = (!pf_valid_q || bus.out_ready) && !rd_done_q;
            ram_rd_en = issue;
            if (issue) begin
               if (cnt_q == LAST) rd_done_d = 1'b1;
               else               cnt_d     = cnt_q + 1'b1;
            end
            pf_valid_d = issue || (pf_valid_q && !bus.out_ready);
            if (pf_valid_q && bus.out_ready && rd_done_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ok_q       <= 1'b0;
         fail_q     <= 1'b0;
         err_q      <= 1'b0;
         pf_valid_q <= 1'b0;
         rd_done_q  <= 1'b0;
         sys_pend_q <= 1'b0;
         sys_hold_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ok_q       <= ok_d;
         fail_q     <= fail_d;
         err_q      <= err_d;
         pf_valid_q <= pf_valid_d;
         rd_done_q  <= rd_done_d;
         sys_pend_q <= (state_q == ST_RUN) && bus.sys_rd_en;
         if (sys_pend_q) sys_hold_q <= ram_rd_data;
      end
   end

   assign bus.in_ready    = (state_q == ST_LOAD);
   assign bus.sys_start   = (state_q == ST_START);
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.out_valid   = pf_valid_q;
   assign bus.out_data    = ram_rd_data;
   // The RAM output is shared with unload, so the systemizer sees a held copy once its read is consumed.
   assign bus.sys_rd_data = sys_pend_q ? ram_rd_data : sys_hold_q;
   assign bus.res_ok      = ok_q;
   assign bus.res_fail    = fail_q;
   assign bus.err_elem    = err_q;

endmodule

// File: tb/tb_mat_loader.sv
// Directed bench for mat_loader: four jobs covering plain load/unload,
// element scrubbing, systemizer RAM access, output back-pressure, failure
// status and a reset in the middle of a load.

module tb_mat_loader;
   import mat_loader_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mat_loader_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

   mat_loader #(.L(8), .K(10), .N(2), .Q(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int start_cnt = 0;
   logic [WW-1:0] exp_q [$];

   // Count systemizer start pulses.
   always @(negedge clk) if (bus.sys_start === 1'b1) start_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word i carries i mod 9 written as two base-3 digits.
   function automatic logic [WW-1:0] make_word(input int i);
      int v = i % 9;
      return {EW'(v / 3), EW'(v % 3)};
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},     bus.busy, 0);
      check({tag, "_in_ready"}, bus.in_ready, 0);
      check({tag, "_out_valid"},bus.out_valid, 0);
      check({tag, "_sys_start"},bus.sys_start, 0);
      check({tag, "_res_ok"},   bus.res_ok, 0);
      check({tag, "_res_fail"}, bus.res_fail, 0);
      check({tag, "_err_elem"}, bus.err_elem, 0);
      check({tag, "_sys_rd"},   bus.sys_rd_data, 0);
   endtask

   task automatic start_job();
      @(negedge clk); bus.cmd_load = 1'b1;
      @(negedge clk); bus.cmd_load = 1'b0;
      check("job_busy", bus.busy, 1);
      check("job_in_ready", bus.in_ready, 1);
      check("job_res_ok_clr", bus.res_ok, 0);
      check("job_res_fail_clr", bus.res_fail, 0);
      check("job_err_clr", bus.err_elem, 0);
   endtask

   // Drive all load beats back-to-back; ends at the first RUN negedge.
   task automatic load_words(input int bad_at, input int abort_at, output bit aborted);
      aborted = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [WW-1:0] w;
         if (i == abort_at) begin
            rst_n = 1'b0;
            bus.in_valid = 1'b0;
            #1;
            check_idle_outputs("rst");
            exp_q.delete();
            aborted = 1'b1;
            return;
         end
         check("load_in_ready", bus.in_ready, 1);
         w = make_word(i);
         if (i == bad_at) begin
            w = 4'b1101;
            exp_q.push_back(4'b0001);
         end else begin
            exp_q.push_back(w);
         end
         bus.in_valid = 1'b1;
         bus.in_data  = w;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("start_pulse", bus.sys_start, 1);
      check("start_in_ready", bus.in_ready, 0);
      @(negedge clk);
      check("start_once", bus.sys_start, 0);
   endtask

   task automatic finish_run(input bit ok, input bit fl);
      bus.sys_done = 1'b1; bus.sys_success = ok; bus.sys_fail = fl;
      @(negedge clk);
      bus.sys_done = 1'b0; bus.sys_success = 1'b0; bus.sys_fail = 1'b0;
      check("res_ok", bus.res_ok, 32'(ok));
      check("res_fail", bus.res_fail, 32'(fl));
      check("unload_first_cycle_valid", bus.out_valid, 0);
      check("unload_busy", bus.busy, 1);
   endtask

   task automatic unload(input bit stall, input bit expect_b2b);
      int cyc = 0, first = -1, last = -1, n = 0;
      bit held_v = 1'b0;
      logic [WW-1:0] held = '0;
      logic [WW-1:0] e;
      logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      while (n < DEPTH && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (held_v) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, held);
         end
         bus.out_ready = stall ? pat[$urandom_range(0, 3)] : 1'b1;
         held_v = 1'b0;
         if (bus.out_valid === 1'b1) begin
            if (bus.out_ready) begin
               e = exp_q.pop_front();
               check("word", bus.out_data, e);
               if (first < 0) first = cyc;
               last = cyc;
               n++;
            end else begin
               held_v = 1'b1;
               held   = bus.out_data;
            end
         end
      end
      check("unload_count", n, DEPTH);
      if (expect_b2b) begin
         check("first_latency", first, 1);
         check("b2b_span", last - first, DEPTH - 1);
      end
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("end_busy", bus.busy, 0);
      check("end_out_valid", bus.out_valid, 0);
   endtask

   initial begin
      bit ab;
      int s0;
      logic [WW-1:0] old5;
      bus.cmd_load = 0; bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      bus.sys_done = 0; bus.sys_fail = 0; bus.sys_success = 0;
      bus.sys_rd_en = 0; bus.sys_rd_addr = '0;
      bus.sys_wr_en = 0; bus.sys_wr_addr = '0; bus.sys_wr_data = '0;

      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Job 1: clean data, systemizer idle, receiver always ready.
      s0 = start_cnt;
      start_job();
      load_words(-1, -1, ab);
      repeat (3) @(negedge clk);
      check("run_busy", bus.busy, 1);
      check("run_in_ready", bus.in_ready, 0);
      finish_run(1'b1, 1'b0);
      unload(1'b0, 1'b1);
      check("start_pulses", start_cnt - s0, 1);

      // Job 2: bad element, RAM write/read collision, failure, back-pressure.
      start_job();
      load_words(3, -1, ab);
      check("err_after_load", bus.err_elem, 1);
      old5 = exp_q[5];
      exp_q[5] = 4'hA;
      bus.sys_wr_en = 1; bus.sys_wr_addr = 6'd5; bus.sys_wr_data = 4'hA;
      bus.sys_rd_en = 1; bus.sys_rd_addr = 6'd5;
      bus.cmd_load  = 1;
      @(negedge clk);
      check("rd_old", bus.sys_rd_data, old5);
      check("cmd_in_run_ignored", bus.in_ready, 0);
      bus.sys_wr_en = 0; bus.cmd_load = 0;
      @(negedge clk);
      check("rd_new", bus.sys_rd_data, 4'hA);
      bus.sys_rd_en = 0;
      @(negedge clk);
      check("rd_hold", bus.sys_rd_data, 4'hA);
      check("err_in_run", bus.err_elem, 1);
      finish_run(1'b0, 1'b1);
      unload(1'b1, 1'b0);
      check("rd_hold_after_unload", bus.sys_rd_data, 4'hA);
      check("err_sticky", bus.err_elem, 1);
      check("fail_sticky", bus.res_fail, 1);

      // Job 3: reset during load beat 20.
      start_job();
      load_words(2, 20, ab);
      check("aborted", 32'(ab), 1);
      repeat (2) @(negedge clk);
      check("rst_hold_busy", bus.busy, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_idle", bus.busy, 0);
      check("post_rst_in_ready", bus.in_ready, 0);

      // Job 4: full job after the abort, with back-pressure.
      s0 = start_cnt;
      start_job();
      load_words(-1, -1, ab);
      finish_run(1'b1, 1'b0);
      unload(1'b1, 1'b0);
      check("start_pulses_2", start_cnt - s0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mat_loader.md
MAT_LOADER -- requirements
Module: mat_loader

Interface
REQ-001 Parameter L, default 8: matrix rows.
REQ-002 Parameter K, default 10: matrix columns.
REQ-003 Parameter N, default 2: field elements per memory word.
REQ-004 Parameter Q, default 3: field order; element width EW = CLOG2(Q), word width WW = N*EW, DEPTH = L*K/N, AW = CLOG2(DEPTH).
REQ-005 Ports, clock and reset first:
 - clk  in  1  sole clock.
 - rst_n  in  1  asynchronous active-low reset.
 - cmd_load  in  1  one-cycle pulse; starts a load/solve/unload job.
 - in_valid  in  1 / in_data  in  WW / in_ready  out  1: host load stream.
 - out_valid  out  1 / out_data  out  WW / out_ready  in  1: result stream.
 - sys_start  out  1: one-cycle start pulse to the systemizer.
 - sys_done, sys_fail, sys_success  in  1 each: systemizer completion and status.
 - sys_rd_en  in  1 / sys_rd_addr  in  AW / sys_rd_data  out  WW: systemizer read port.
 - sys_wr_en  in  1 / sys_wr_addr  in  AW / sys_wr_data  in  WW: systemizer write port.
 - busy  out  1: FSM not in IDLE.
 - res_ok, res_fail, err_elem  out  1 each: latched job status.

Function
REQ-006 FSM states IDLE, LOAD, START, RUN, UNLOAD; one state per job phase.
REQ-007 IDLE -> LOAD on cmd_load; on that transition clear res_ok, res_fail and err_elem and zero the word counter; cmd_load outside IDLE is ignored.
REQ-008 LOAD: in_ready = 1; each in_valid&&in_ready beat writes in_data to address = counter and increments the counter.
REQ-009 Any element of a LOAD beat with value >= Q is stored as 0 and sets err_elem (sticky until the next job).
REQ-010 LOAD -> START in the cycle the beat at address DEPTH-1 is accepted; in_ready = 0 in every other state.
REQ-011 START: sys_start = 1 for exactly one cycle, then RUN.
REQ-012 RUN: the systemizer owns the memory; a sys_rd_en read returns sys_rd_data one cycle later.
REQ-013 RUN: a sys_wr_en write takes effect at the clock edge; a read and write to the same address in one cycle returns the old data.
REQ-014 The sys_* memory ports are ignored outside RUN, and sys_rd_data holds its last value.
REQ-015 RUN -> UNLOAD on sys_done; in the same edge latch res_ok = sys_success and res_fail = sys_fail; zero the counter.
REQ-016 UNLOAD streams addresses 0..DEPTH-1 in order on out_data.
REQ-017 out_data is stable while out_valid && !out_ready.
REQ-018 UNLOAD uses a one-entry prefetch/skid buffer so full throughput is one word per cycle when out_ready stays high; first out_valid is 1 cycle after entering UNLOAD.
REQ-019 UNLOAD -> IDLE after the handshake of word DEPTH-1; out_valid = 0 outside UNLOAD.
REQ-020 The counter is AW bits wide and never wraps within a phase; terminal value is DEPTH-1.
REQ-021 Memory contents are not reset.

Reset
REQ-022 While rst_n = 0: state = IDLE; counter = 0; in_ready, out_valid, sys_start, busy, res_ok, res_fail and err_elem = 0; sys_rd_data = 0.
REQ-023 Reset assertion mid-job aborts the job immediately with no further memory writes; after release the block waits for a new cmd_load.

Structure
REQ-024 The shared package holds the FSM state encoding, the CLOG2 macro, and the derived constants EW, WW, DEPTH and AW.
REQ-025 The DEPTH x WW array with the single-read/single-write port is sub-module mat_ram; the FSM, port muxing and skid buffer stay in mat_loader.

Verification
REQ-026 Load words 0..39 with value i mod 9 (elements in 0..2), systemizer model writes nothing, out_ready = 1 -> sys_start pulses once, 40 words return in order with identical values, back-to-back.
REQ-027 Load beat with in_data = 4'b1101 -> stored and returned as 4'b0001, err_elem = 1 until the next cmd_load.
REQ-028 RUN: write addr 5 = 4'hA and read addr 5 in the same cycle -> old value returned; a read the next cycle returns 4'hA; UNLOAD word 5 = 4'hA.
REQ-029 out_ready toggles 1,0,0,1 pseudo-randomly during UNLOAD -> no word lost or duplicated, out_data stable while stalled.
REQ-030 sys_done with sys_fail = 1 -> res_fail = 1, res_ok = 0, and the unload still occurs; cmd_load during RUN is ignored.
REQ-031 rst_n pulled low at load beat 20, then a new full job -> all outputs at reset values during reset, and the second job completes correctly.
